// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/LSB handshakes and the byte-wide RAM/IO bus around mem_arbiter
interface mem_arbiter_if #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                    rdy;
    logic                    rollback;
    logic                    if_en;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_finish;
    logic [8*LINE_BYTES-1:0] if_line;
    logic                    ls_en;
    logic                    ls_wr;
    logic [1:0]              ls_size;
    logic [ADDR_WIDTH-1:0]   ls_addr;
    logic [31:0]             ls_wdata;
    logic                    ls_finish;
    logic [31:0]             ls_rdata;
    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [ADDR_WIDTH-1:0]   mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;
    modport master (
        input  rdy, rollback, if_en, if_addr, ls_en, ls_wr, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
        output if_finish, if_line, ls_finish, ls_rdata, mem_dout, mem_a, mem_wr
    );
    modport slave (
        output rdy, rollback, if_en, if_addr, ls_en, ls_wr, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
        input  if_finish, if_line, ls_finish, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port byte bus owner for icache line fetches and LSB loads/stores (MEM_ARBITER_RR_EN selects round-robin ties)
module mem_arbiter #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.master bus
);
    localparam int IW = $clog2(LINE_BYTES);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
    state_t                       state;
    logic [4:0]                   cnt;
    logic [4:0]                   len;
    logic [4:0]                   ls_len;
    logic [ADDR_WIDTH-1:0]        base;
    logic [ADDR_WIDTH-1:0]        mem_a_q;
    logic [ADDR_WIDTH-1:0]        nxt_addr;
    logic [31:0]                  wdata;
    logic [31:0]                  wshift;
    logic [LINE_BYTES-1:0][7:0]   dbuf;
    logic [LINE_BYTES-1:0][7:0]   buf_nx;
    logic [IW-1:0]                widx;
    logic [7:0]                   dout_q;
    logic                         wr_q;
    logic                         if_fin_q;
    logic                         ls_fin_q;
    logic [8*LINE_BYTES-1:0]      line_q;
    logic [31:0]                  rdata_q;
    logic                         rdy_q;
    logic                         skip;
    logic                         ls_ok;
    logic                         if_ok;
    logic                         pick_ls;
    logic                         grant_stall;
    logic                         store_stall;
    assign ls_ok       = bus.ls_en && !ls_fin_q && (bus.ls_wr || !bus.rollback);
    assign if_ok       = bus.if_en && !if_fin_q && !bus.rollback;
    assign ls_len      = bus.ls_size == 2'd0 ? 5'd1 : bus.ls_size == 2'd1 ? 5'd2 : 5'd4;
    assign nxt_addr    = base + ADDR_WIDTH'(cnt);
    assign wshift      = wdata >> {cnt[1:0], 3'b000};
    assign widx        = IW'(cnt - 5'd2);
    assign grant_stall = bus.ls_addr[17:16] == 2'b11 && bus.io_buffer_full;
    assign store_stall = nxt_addr[17:16] == 2'b11 && bus.io_buffer_full;
`ifdef MEM_ARBITER_RR_EN
    logic last_ls;
    // Remember which requester won the last grant so that ties alternate
    always_ff @(posedge clk) begin
        if (rst)
            last_ls <= 1'b0;
        else if (bus.rdy && state == IDLE && (ls_ok || if_ok))
            last_ls <= ls_ok && pick_ls;
    end
    assign pick_ls = !if_ok || !last_ls;
`else
    assign pick_ls = 1'b1;
`endif
    // Byte on mem_din belongs to the address issued two cycles into the read; slot it in unless a rewind left it stale
    always_comb begin
        buf_nx = dbuf;
        if (cnt >= 5'd2 && !skip)
            buf_nx[widx] = bus.mem_din;
    end
    // Grant, sequence and retire transfers; after an rdy freeze a read steps back two addresses to refill the RAM pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            len      <= 5'd0;
            base     <= '0;
            wdata    <= 32'd0;
            dbuf     <= '0;
            mem_a_q  <= '0;
            dout_q   <= 8'd0;
            wr_q     <= 1'b0;
            if_fin_q <= 1'b0;
            ls_fin_q <= 1'b0;
            line_q   <= '0;
            rdata_q  <= 32'd0;
            rdy_q    <= 1'b1;
            skip     <= 1'b0;
        end else begin
            rdy_q <= bus.rdy;
            if (bus.rdy) begin
                if_fin_q <= 1'b0;
                ls_fin_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (ls_ok && pick_ls) begin
                            state   <= bus.ls_wr ? STORE : LOAD;
                            base    <= bus.ls_addr;
                            wdata   <= bus.ls_wdata;
                            len     <= ls_len;
                            mem_a_q <= bus.ls_addr;
                            dout_q  <= bus.ls_wdata[7:0];
                            dbuf    <= '0;
                            skip    <= 1'b0;
                            wr_q    <= bus.ls_wr && !grant_stall;
                            cnt     <= bus.ls_wr && grant_stall ? 5'd0 : 5'd1;
                        end else if (if_ok) begin
                            state   <= FETCH;
                            base    <= bus.if_addr;
                            len     <= 5'(LINE_BYTES);
                            mem_a_q <= bus.if_addr;
                            dbuf    <= '0;
                            skip    <= 1'b0;
                            wr_q    <= 1'b0;
                            cnt     <= 5'd1;
                        end
                    end
                    STORE: begin
                        if (cnt == len) begin
                            state    <= IDLE;
                            cnt      <= 5'd0;
                            wr_q     <= 1'b0;
                            ls_fin_q <= 1'b1;
                        end else if (store_stall) begin
                            wr_q <= 1'b0;
                        end else begin
                            mem_a_q <= nxt_addr;
                            dout_q  <= wshift[7:0];
                            wr_q    <= 1'b1;
                            cnt     <= cnt + 5'd1;
                        end
                    end
                    default: begin
                        if (bus.rollback) begin
                            state <= IDLE;
                            cnt   <= 5'd0;
                            skip  <= 1'b0;
                        end else if (!rdy_q && cnt >= 5'd2 && cnt <= len) begin
                            mem_a_q <= nxt_addr - ADDR_WIDTH'(2);
                            cnt     <= cnt - 5'd1;
                            skip    <= 1'b1;
                        end else begin
                            dbuf <= buf_nx;
                            skip <= 1'b0;
                            if (cnt < len)
                                mem_a_q <= nxt_addr;
                            if (cnt == len + 5'd1) begin
                                state <= IDLE;
                                cnt   <= 5'd0;
                                if (state == FETCH) begin
                                    if_fin_q <= 1'b1;
                                    line_q   <= buf_nx;
                                end else begin
                                    ls_fin_q <= 1'b1;
                                    rdata_q  <= buf_nx[3:0];
                                end
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = dout_q;
    assign bus.mem_wr    = wr_q && bus.rdy;
    assign bus.if_finish = if_fin_q;
    assign bus.if_line   = line_q;
    assign bus.ls_finish = ls_fin_q;
    assign bus.ls_rdata  = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic seen;
    logic [7:0] ram [0:262143];
    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Registered RAM read: address of cycle i returns data in cycle i+1
    always @(posedge clk) bus.mem_din <= ram[bus.mem_a[17:0]];
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ls(input string tag, input logic [31:0] exp);
        int k = 0;
        while (!bus.ls_finish && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_fin"}, bus.ls_finish, 1'b1);
        check(tag, bus.ls_rdata, exp);
        bus.ls_en = 1'b0;
    endtask
    initial begin
        for (int k = 0; k < 16; k++) ram[18'h100 + k] = 8'(k);
        ram[18'h204] = 8'h78;
        ram[18'h205] = 8'h56;
        ram[18'h206] = 8'h34;
        ram[18'h207] = 8'h12;
        ram[18'h210] = 8'h80;
        bus.rdy = 1'b1;
        bus.rollback = 1'b0;
        bus.if_en = 1'b0;
        bus.if_addr = 32'h0;
        bus.ls_en = 1'b0;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'h0;
        bus.ls_wdata = 32'h0;
        bus.io_buffer_full = 1'b0;
        tick();
        tick();
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_wr", bus.mem_wr, 1'b0);
        check("rst_dout", bus.mem_dout, 8'h0);
        check("rst_if_fin", bus.if_finish, 1'b0);
        check("rst_ls_fin", bus.ls_finish, 1'b0);
        check("rst_if_line", bus.if_line, 128'h0);
        check("rst_rdata", bus.ls_rdata, 32'h0);
        rst = 1'b0;
        tick();
        // line fetch from 0x100; en left high in the finish cycle must not regrant
        bus.if_addr = 32'h100;
        bus.if_en = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c <= 16) check("if_addr", bus.mem_a, 32'h100 + c - 1);
            if (c == 1) check("if_rd", bus.mem_wr, 1'b0);
            if (c == 17) check("if_early", bus.if_finish, 1'b0);
            if (c == 18) begin
                check("if_fin", bus.if_finish, 1'b1);
                check("if_line", bus.if_line, 128'h0F0E0D0C0B0A09080706050403020100);
            end
            if (c == 19) begin
                check("if_noregrant", bus.mem_a, 32'h10F);
                check("if_pulse", bus.if_finish, 1'b0);
                bus.if_en = 1'b0;
            end
        end
        tick();
        // tie with IF granted last: LSB first in both builds, IF right after
        bus.if_en = 1'b1;
        bus.ls_en = 1'b1;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'h210;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 1) check("tieA_first", bus.mem_a, 32'h210);
            if (c == 3) begin
                check("tieA_ls_fin", bus.ls_finish, 1'b1);
                check("tieA_ls_data", bus.ls_rdata, 32'h80);
                bus.ls_en = 1'b0;
            end
            if (c == 4) check("tieA_second", bus.mem_a, 32'h100);
            if (c == 21) begin
                check("tieA_if_fin", bus.if_finish, 1'b1);
                bus.if_en = 1'b0;
            end
        end
        tick();
        // word load, then byte load (upper bytes zero)
        bus.ls_en = 1'b1;
        bus.ls_size = 2'd2;
        bus.ls_addr = 32'h204;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) check("ld_a0", bus.mem_a, 32'h204);
            if (c == 4) check("ld_a3", bus.mem_a, 32'h207);
            if (c == 5) check("ld_early", bus.ls_finish, 1'b0);
            if (c == 6) begin
                check("ld_fin", bus.ls_finish, 1'b1);
                check("ld_word", bus.ls_rdata, 32'h12345678);
                bus.ls_en = 1'b0;
            end
        end
        tick();
        bus.ls_en = 1'b1;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'h210;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                check("ldb_fin", bus.ls_finish, 1'b1);
                check("ldb_data", bus.ls_rdata, 32'h00000080);
                bus.ls_en = 1'b0;
            end
        end
        tick();
        // tie with LSB granted last: fixed priority keeps LSB, round-robin gives IF
        bus.if_en = 1'b1;
        bus.ls_en = 1'b1;
        tick();
`ifdef MEM_ARBITER_RR_EN
        check("tieB_first", bus.mem_a, 32'h100);
`else
        check("tieB_first", bus.mem_a, 32'h210);
`endif
        // reset in the middle of that transfer
        rst = 1'b1;
        bus.if_en = 1'b0;
        bus.ls_en = 1'b0;
        tick();
        check("mid_rst_a", bus.mem_a, 32'h0);
        check("mid_rst_wr", bus.mem_wr, 1'b0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.if_finish || bus.ls_finish) seen = 1'b1;
        end
        check("mid_rst_nofin", seen, 1'b0);
        // half store
        bus.ls_en = 1'b1;
        bus.ls_wr = 1'b1;
        bus.ls_size = 2'd1;
        bus.ls_addr = 32'h300;
        bus.ls_wdata = 32'h0000BEEF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin
                check("st_wr1", bus.mem_wr, 1'b1);
                check("st_a1", bus.mem_a, 32'h300);
                check("st_d1", bus.mem_dout, 8'hEF);
            end
            if (c == 2) begin
                check("st_wr2", bus.mem_wr, 1'b1);
                check("st_a2", bus.mem_a, 32'h301);
                check("st_d2", bus.mem_dout, 8'hBE);
            end
            if (c == 3) begin
                check("st_fin", bus.ls_finish, 1'b1);
                check("st_wr3", bus.mem_wr, 1'b0);
                bus.ls_en = 1'b0;
            end
        end
        tick();
        // rollback in cycle 7 of a fetch
        bus.if_addr = 32'h100;
        bus.if_en = 1'b1;
        for (int c = 1; c <= 7; c++) tick();
        bus.rollback = 1'b1;
        bus.if_en = 1'b0;
        tick();
        bus.rollback = 1'b0;
        check("rb_hold_a", bus.mem_a, 32'h106);
        check("rb_wr", bus.mem_wr, 1'b0);
        seen = 1'b0;
        for (int c = 8; c <= 25; c++) begin
            if (bus.if_finish) seen = 1'b1;
            tick();
        end
        check("rb_nofin", seen, 1'b0);
        // rollback while storing a word to 0x400 (also granted while rollback is high)
        bus.rollback = 1'b1;
        bus.ls_en = 1'b1;
        bus.ls_wr = 1'b1;
        bus.ls_size = 2'd2;
        bus.ls_addr = 32'h400;
        bus.ls_wdata = 32'hA1B2C3D4;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 3) bus.rollback = 1'b0;
            if (c == 1) check("rbst_d0", bus.mem_dout, 8'hD4);
            if (c == 4) begin
                check("rbst_wr", bus.mem_wr, 1'b1);
                check("rbst_a3", bus.mem_a, 32'h403);
                check("rbst_d3", bus.mem_dout, 8'hA1);
            end
            if (c == 5) begin
                check("rbst_fin", bus.ls_finish, 1'b1);
                bus.ls_en = 1'b0;
            end
        end
        tick();
        // non-IO store ignores io_buffer_full
        bus.io_buffer_full = 1'b1;
        bus.ls_en = 1'b1;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'h500;
        bus.ls_wdata = 32'h33;
        tick();
        check("nio_wr", bus.mem_wr, 1'b1);
        tick();
        check("nio_fin", bus.ls_finish, 1'b1);
        bus.ls_en = 1'b0;
        tick();
        // IO store stalled three cycles
        bus.ls_en = 1'b1;
        bus.ls_addr = 32'h30000;
        bus.ls_wdata = 32'h5A;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 3) bus.io_buffer_full = 1'b0;
            if (c <= 3) check("io_stall", bus.mem_wr, 1'b0);
            if (c == 4) begin
                check("io_wr", bus.mem_wr, 1'b1);
                check("io_a", bus.mem_a, 32'h30000);
                check("io_d", bus.mem_dout, 8'h5A);
            end
            if (c == 5) begin
                check("io_fin", bus.ls_finish, 1'b1);
                bus.ls_en = 1'b0;
            end
        end
        tick();
        // load requested under rollback waits one cycle
        bus.rollback = 1'b1;
        bus.ls_en = 1'b1;
        bus.ls_wr = 1'b0;
        bus.ls_addr = 32'h210;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                check("rbi_nogrant", bus.mem_a, 32'h30000);
                bus.rollback = 1'b0;
            end
            if (c == 2) check("rbi_a", bus.mem_a, 32'h210);
            if (c == 4) begin
                check("rbi_fin", bus.ls_finish, 1'b1);
                check("rbi_data", bus.ls_rdata, 32'h80);
                bus.ls_en = 1'b0;
            end
        end
        tick();
        // rdy low mid word load: no byte lost or duplicated
        bus.ls_size = 2'd2;
        bus.ls_addr = 32'h204;
        bus.ls_en = 1'b1;
        tick();
        tick();
        bus.rdy = 1'b0;
        tick();
        tick();
        bus.rdy = 1'b1;
        wait_ls("rdy_ld", 32'h12345678);
        tick();
        // rdy low during a store suppresses the write strobe
        bus.ls_en = 1'b1;
        bus.ls_wr = 1'b1;
        bus.ls_size = 2'd0;
        bus.ls_addr = 32'h600;
        bus.ls_wdata = 32'h77;
        tick();
        bus.rdy = 1'b0;
        #1;
        check("rdy_st_off", bus.mem_wr, 1'b0);
        tick();
        bus.rdy = 1'b1;
        #1;
        check("rdy_st_on", bus.mem_wr, 1'b1);
        check("rdy_st_d", bus.mem_dout, 8'h77);
        tick();
        check("rdy_st_fin", bus.ls_finish, 1'b1);
        bus.ls_en = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
